// File: rtl/dfmon_pkg.sv
// Shared types and helpers for the dataflow performance counter bank.
package dfmon_pkg;

  // Common width used to carry statistics between channel and read mux.
  localparam int unsigned STAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    SEL_TXN_CNT   = 3'd0,
    SEL_BUSY_CYC  = 3'd1,
    SEL_LAST_LAT  = 3'd2,
    SEL_MIN_LAT   = 3'd3,
    SEL_MAX_LAT   = 3'd4,
    SEL_STALL_CYC = 3'd5,
    SEL_ITER_CNT  = 3'd6,
    SEL_HOLD_CYC  = 3'd7
  } stat_sel_e;

  // Per-channel statistics, zero-extended to STAT_W.
  typedef struct packed {
    logic [STAT_W-1:0] txn_cnt;
    logic [STAT_W-1:0] busy_cyc;
    logic [STAT_W-1:0] last_lat;
    logic [STAT_W-1:0] min_lat;
    logic [STAT_W-1:0] max_lat;
    logic [STAT_W-1:0] stall_cyc;
    logic [STAT_W-1:0] iter_cnt;
    logic [STAT_W-1:0] hold_cyc;
  } ch_stats_t;

  // Result of a saturating add: clip is set when the true sum exceeded the limit.
  typedef struct packed {
    logic              clip;
    logic [STAT_W-1:0] val;
  } sat_res_t;

  // Saturating add of two values that are each at most 2^w-1.
  function automatic sat_res_t sat_add(input logic [STAT_W-1:0] a,
                                       input logic [STAT_W-1:0] b,
                                       input int unsigned       w);
    sat_res_t        res;
    logic [STAT_W:0] sum;
    logic [STAT_W:0] max_v;
    if (w >= STAT_W) begin
      max_v = {1'b0, {STAT_W{1'b1}}};
    end else begin
      max_v = ({{STAT_W{1'b0}}, 1'b1} << w) - {{STAT_W{1'b0}}, 1'b1};
    end
    sum = {1'b0, a} + {1'b0, b};
    if (sum > max_v) begin
      res.clip = 1'b1;
      res.val  = max_v[STAT_W-1:0];
    end else begin
      res.clip = 1'b0;
      res.val  = sum[STAT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/perf_channel.sv
// One monitored channel: handshake FSM plus its saturating statistics.
module perf_channel
  import dfmon_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      enable,
  input  logic      clear,
  input  logic      ap_start,
  input  logic      ap_done,
  input  logic      ap_continue,
  input  logic      iter_end,
  input  logic      stall,
  output ch_stats_t stats,
  output logic      busy,
  output logic      overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating add at this channel's counter width.
  function automatic sat_res_t sat_inc(input logic [CNT_W-1:0] a,
                                       input logic [CNT_W-1:0] b);
    return sat_add(STAT_W'(a), STAT_W'(b), CNT_W);
  endfunction

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0] busy_cyc_q, busy_cyc_d;
  logic [CNT_W-1:0] last_lat_q, last_lat_d;
  logic [CNT_W-1:0] min_lat_q, min_lat_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0] hold_cyc_q, hold_cyc_d;
  logic             overflow_q, overflow_d;

  logic             complete_s;
  logic             clip_s;
  logic [CNT_W-1:0] done_lat_s;
  sat_res_t         lat_inc_s, txn_inc_s, busy_add_s;
  sat_res_t         stall_inc_s, iter_inc_s, hold_inc_s;

  // Next-state and statistics update; clear beats enable, disabled cycles freeze.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    txn_cnt_d   = txn_cnt_q;
    busy_cyc_d  = busy_cyc_q;
    last_lat_d  = last_lat_q;
    min_lat_d   = min_lat_q;
    max_lat_d   = max_lat_q;
    stall_cyc_d = stall_cyc_q;
    iter_cnt_d  = iter_cnt_q;
    hold_cyc_d  = hold_cyc_q;
    overflow_d  = overflow_q;
    complete_s  = 1'b0;
    clip_s      = 1'b0;
    done_lat_s  = lat_cnt_q;
    lat_inc_s   = sat_inc(lat_cnt_q, CNT_ONE);
    txn_inc_s   = sat_inc(txn_cnt_q, CNT_ONE);
    stall_inc_s = sat_inc(stall_cyc_q, CNT_ONE);
    iter_inc_s  = sat_inc(iter_cnt_q, CNT_ONE);
    hold_inc_s  = sat_inc(hold_cyc_q, CNT_ONE);
    busy_add_s  = sat_inc(busy_cyc_q, CNT_ZERO);

    if (clear) begin
      state_d     = IDLE;
      lat_cnt_d   = CNT_ZERO;
      txn_cnt_d   = CNT_ZERO;
      busy_cyc_d  = CNT_ZERO;
      last_lat_d  = CNT_ZERO;
      min_lat_d   = CNT_MAX;
      max_lat_d   = CNT_ZERO;
      stall_cyc_d = CNT_ZERO;
      iter_cnt_d  = CNT_ZERO;
      hold_cyc_d  = CNT_ZERO;
      overflow_d  = 1'b0;
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            // The start cycle itself counts as the first latency cycle.
            lat_cnt_d  = CNT_ONE;
            done_lat_s = CNT_ONE;
            if (ap_done && ap_continue) begin
              complete_s = 1'b1;
              state_d    = IDLE;
            end else if (ap_done) begin
              state_d = HOLD;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          lat_cnt_d  = CNT_W'(lat_inc_s.val);
          done_lat_s = CNT_W'(lat_inc_s.val);
          clip_s     = lat_inc_s.clip;
          if (ap_done && ap_continue) begin
            complete_s = 1'b1;
            state_d    = IDLE;
          end else if (ap_done) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
        HOLD: begin
          // Latency was frozen at done; only the hold counter advances here.
          hold_cyc_d = CNT_W'(hold_inc_s.val);
          clip_s     = hold_inc_s.clip;
          if (ap_continue) begin
            complete_s = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (stall && (state_q != IDLE)) begin
        stall_cyc_d = CNT_W'(stall_inc_s.val);
        clip_s      = clip_s | stall_inc_s.clip;
      end else begin
        stall_cyc_d = stall_cyc_q;
      end

      if (iter_end) begin
        iter_cnt_d = CNT_W'(iter_inc_s.val);
        clip_s     = clip_s | iter_inc_s.clip;
      end else begin
        iter_cnt_d = iter_cnt_q;
      end

      busy_add_s = sat_inc(busy_cyc_q, done_lat_s);
      if (complete_s) begin
        txn_cnt_d  = CNT_W'(txn_inc_s.val);
        busy_cyc_d = CNT_W'(busy_add_s.val);
        last_lat_d = done_lat_s;
        min_lat_d  = (done_lat_s < min_lat_q) ? done_lat_s : min_lat_q;
        max_lat_d  = (done_lat_s > max_lat_q) ? done_lat_s : max_lat_q;
        clip_s     = clip_s | txn_inc_s.clip | busy_add_s.clip;
      end else begin
        txn_cnt_d = txn_cnt_q;
      end

      overflow_d = overflow_q | clip_s;
    end else begin
      state_d = state_q;
    end
  end

  // State and statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= CNT_ZERO;
      txn_cnt_q   <= CNT_ZERO;
      busy_cyc_q  <= CNT_ZERO;
      last_lat_q  <= CNT_ZERO;
      min_lat_q   <= CNT_MAX;
      max_lat_q   <= CNT_ZERO;
      stall_cyc_q <= CNT_ZERO;
      iter_cnt_q  <= CNT_ZERO;
      hold_cyc_q  <= CNT_ZERO;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      txn_cnt_q   <= txn_cnt_d;
      busy_cyc_q  <= busy_cyc_d;
      last_lat_q  <= last_lat_d;
      min_lat_q   <= min_lat_d;
      max_lat_q   <= max_lat_d;
      stall_cyc_q <= stall_cyc_d;
      iter_cnt_q  <= iter_cnt_d;
      hold_cyc_q  <= hold_cyc_d;
      overflow_q  <= overflow_d;
    end
  end

  // Present registered statistics to the read mux.
  always_comb begin
    stats.txn_cnt   = STAT_W'(txn_cnt_q);
    stats.busy_cyc  = STAT_W'(busy_cyc_q);
    stats.last_lat  = STAT_W'(last_lat_q);
    stats.min_lat   = STAT_W'(min_lat_q);
    stats.max_lat   = STAT_W'(max_lat_q);
    stats.stall_cyc = STAT_W'(stall_cyc_q);
    stats.iter_cnt  = STAT_W'(iter_cnt_q);
    stats.hold_cyc  = STAT_W'(hold_cyc_q);
  end

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: rtl/dataflow_perf_counter_bank.sv
// Multi-channel dataflow profiling counters with a registered read port.
module dataflow_perf_counter_bank
  import dfmon_pkg::*;
#(
  parameter int          NUM_CH = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_end,
  input  logic [NUM_CH-1:0] stall,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] overflow
);

  ch_stats_t         stats_s [NUM_CH];
  logic [NUM_CH-1:0] busy_s;
  logic [NUM_CH-1:0] overflow_s;
  ch_stats_t         sel_stats_s;
  logic              sel_hit_s;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .clear       (clear),
      .ap_start    (ap_start[g]),
      .ap_done     (ap_done[g]),
      .ap_continue (ap_continue[g]),
      .iter_end    (iter_end[g]),
      .stall       (stall[g]),
      .stats       (stats_s[g]),
      .busy        (busy_s[g]),
      .overflow    (overflow_s[g])
    );
  end

  // Read mux over current register values; out-of-range channels read as zero.
  always_comb begin
    sel_stats_s = '{default: {STAT_W{1'b0}}};
    sel_hit_s   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_ch) == i) begin
        sel_stats_s = stats_s[i];
        sel_hit_s   = 1'b1;
      end else begin
        sel_hit_s = sel_hit_s;
      end
    end
    rd_valid_d = rd_req;
    rd_data_d  = {CNT_W{1'b0}};
    if (rd_req && sel_hit_s) begin
      case (stat_sel_e'(rd_sel))
        SEL_TXN_CNT:   rd_data_d = CNT_W'(sel_stats_s.txn_cnt);
        SEL_BUSY_CYC:  rd_data_d = CNT_W'(sel_stats_s.busy_cyc);
        SEL_LAST_LAT:  rd_data_d = CNT_W'(sel_stats_s.last_lat);
        SEL_MIN_LAT:   rd_data_d = CNT_W'(sel_stats_s.min_lat);
        SEL_MAX_LAT:   rd_data_d = CNT_W'(sel_stats_s.max_lat);
        SEL_STALL_CYC: rd_data_d = CNT_W'(sel_stats_s.stall_cyc);
        SEL_ITER_CNT:  rd_data_d = CNT_W'(sel_stats_s.iter_cnt);
        SEL_HOLD_CYC:  rd_data_d = CNT_W'(sel_stats_s.hold_cyc);
        default:       rd_data_d = {CNT_W{1'b0}};
      endcase
    end else begin
      rd_data_d = {CNT_W{1'b0}};
    end
  end

  // Read response registers, one cycle after the request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= {CNT_W{1'b0}};
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ch_busy  = busy_s;
  assign overflow = overflow_s;

endmodule
